// File: rtl/ex_muldiv_pkg.sv
// Shared constants and state encoding for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

    localparam int unsigned DEFAULT_DATA_SIZE = 32;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/ex_muldiv_unit_core.sv
// Iteration datapath: 2*DATA_SIZE accumulator with one shift-add or one
// restoring-subtract step per enabled cycle on unsigned magnitudes.
module muldiv_iter_core
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DEFAULT_DATA_SIZE
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic                     i_is_div,
    input  logic                     i_step,
    input  logic [DATA_SIZE-1:0]     i_op_a,
    input  logic [DATA_SIZE-1:0]     i_op_b,
    output logic [2*DATA_SIZE-1:0]   o_acc
);

    localparam int unsigned ACC_SIZE = 2 * DATA_SIZE;

    logic [ACC_SIZE-1:0]  acc;
    logic [ACC_SIZE-1:0]  acc_next;
    logic [DATA_SIZE-1:0] op_b;
    logic [DATA_SIZE:0]   add_sum;
    logic [DATA_SIZE:0]   rem_shift;
    logic [DATA_SIZE:0]   sub_diff;

    // Multiply: upper half accumulates, lower half shifts out multiplier bits.
    // Divide: upper half is the partial remainder, lower half collects quotient bits.
    always_comb begin
        acc_next  = acc;
        add_sum   = {1'b0, acc[ACC_SIZE-1:DATA_SIZE]}
                  + (acc[0] ? {1'b0, op_b} : (DATA_SIZE+1)'(0));
        rem_shift = acc[ACC_SIZE-1:DATA_SIZE-1];
        sub_diff  = rem_shift - {1'b0, op_b};
        if (i_is_div) begin
            if (rem_shift >= {1'b0, op_b}) begin
                acc_next = {sub_diff[DATA_SIZE-1:0], acc[DATA_SIZE-2:0], 1'b1};
            end else begin
                acc_next = {rem_shift[DATA_SIZE-1:0], acc[DATA_SIZE-2:0], 1'b0};
            end
        end else begin
            acc_next = {add_sum, acc[DATA_SIZE-1:1]};
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc  <= '0;
            op_b <= '0;
        end else if (i_start) begin
            acc  <= {{DATA_SIZE{1'b0}}, i_op_a};
            op_b <= i_op_b;
        end else if (i_step) begin
            acc  <= acc_next;
        end
    end

    assign o_acc = acc;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, sequences the iterative core,
// applies sign correction and requests pipeline stalls while busy.
module ex_muldiv_unit
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned DATA_SIZE   = DEFAULT_DATA_SIZE,
    parameter int unsigned OPCODE_SIZE = 6,
    parameter int unsigned CNT_SIZE    = 6
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic [OPCODE_SIZE-1:0] i_alu_op,
    input  logic [DATA_SIZE-1:0]   i_data_a,
    input  logic [DATA_SIZE-1:0]   i_data_b,
    input  logic                   i_hilo_read,
    output logic [DATA_SIZE-1:0]   o_hi,
    output logic [DATA_SIZE-1:0]   o_lo,
    output logic                   o_busy,
    output logic                   o_stall,
    output logic                   o_done,
    output logic                   o_div_by_zero
);

    localparam logic [CNT_SIZE-1:0] LAST_CNT = CNT_SIZE'(DATA_SIZE - 1);

    state_e                 state;
    state_e                 state_next;
    logic [CNT_SIZE-1:0]    cnt;
    logic [DATA_SIZE-1:0]   hi_q;
    logic [DATA_SIZE-1:0]   lo_q;
    logic                   done_q;
    logic                   dbz_q;
    logic                   op_is_div;
    logic                   neg_res;
    logic                   neg_rem;

    logic                   op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
    logic                   op_muldiv, op_divide, op_signed, div_zero, accept;
    logic                   sign_a, sign_b;
    logic [DATA_SIZE-1:0]   mag_a, mag_b;
    logic                   core_start, core_step, fix_write;
    logic [2*DATA_SIZE-1:0] acc;
    logic [2*DATA_SIZE-1:0] prod;
    logic [DATA_SIZE-1:0]   quo, rem;

    // Opcode decode and operand magnitudes (two's complement of the min value is itself).
    assign op_mult   = (i_alu_op == OPCODE_SIZE'(FUNCT_MULT));
    assign op_multu  = (i_alu_op == OPCODE_SIZE'(FUNCT_MULTU));
    assign op_div    = (i_alu_op == OPCODE_SIZE'(FUNCT_DIV));
    assign op_divu   = (i_alu_op == OPCODE_SIZE'(FUNCT_DIVU));
    assign op_mthi   = (i_alu_op == OPCODE_SIZE'(FUNCT_MTHI));
    assign op_mtlo   = (i_alu_op == OPCODE_SIZE'(FUNCT_MTLO));
    assign op_divide = op_div | op_divu;
    assign op_muldiv = op_mult | op_multu | op_divide;
    assign op_signed = op_mult | op_div;
    assign div_zero  = (i_data_b == '0);
    assign accept    = (state == IDLE) & i_valid;
    assign sign_a    = op_signed & i_data_a[DATA_SIZE-1];
    assign sign_b    = op_signed & i_data_b[DATA_SIZE-1];
    assign mag_a     = sign_a ? (DATA_SIZE'(0) - i_data_a) : i_data_a;
    assign mag_b     = sign_b ? (DATA_SIZE'(0) - i_data_b) : i_data_b;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        core_start = 1'b0;
        core_step  = 1'b0;
        fix_write  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && op_muldiv && !(op_divide && div_zero)) begin
                    core_start = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                core_step = 1'b1;
                if (cnt == LAST_CNT) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                fix_write  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    muldiv_iter_core #(
        .DATA_SIZE (DATA_SIZE)
    ) u_core (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_start  (core_start),
        .i_is_div (op_is_div),
        .i_step   (core_step),
        .i_op_a   (mag_a),
        .i_op_b   (mag_b),
        .o_acc    (acc)
    );

    // Sign correction: remainder follows the dividend, everything else follows sign_a ^ sign_b.
    assign prod = neg_res ? ((2*DATA_SIZE)'(0) - acc) : acc;
    assign quo  = neg_res ? (DATA_SIZE'(0) - acc[DATA_SIZE-1:0]) : acc[DATA_SIZE-1:0];
    assign rem  = neg_rem ? (DATA_SIZE'(0) - acc[2*DATA_SIZE-1:DATA_SIZE])
                          : acc[2*DATA_SIZE-1:DATA_SIZE];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            cnt       <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            op_is_div <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
        end else begin
            done_q <= fix_write;
            dbz_q  <= accept & op_divide & div_zero;
            if (core_start) begin
                cnt       <= '0;
                op_is_div <= op_divide;
                neg_res   <= sign_a ^ sign_b;
                neg_rem   <= sign_a;
            end else if (core_step) begin
                cnt <= cnt + CNT_SIZE'(1);
            end
            if (fix_write) begin
                hi_q <= op_is_div ? rem : prod[2*DATA_SIZE-1:DATA_SIZE];
                lo_q <= op_is_div ? quo : prod[DATA_SIZE-1:0];
            end else if (accept && op_mthi) begin
                hi_q <= i_data_a;
            end else if (accept && op_mtlo) begin
                lo_q <= i_data_a;
            end
        end
    end

    assign o_hi          = hi_q;
    assign o_lo          = lo_q;
    assign o_done        = done_q;
    assign o_div_by_zero = dbz_q;
    assign o_busy        = (state != IDLE);
    assign o_stall       = o_busy & i_valid & (op_muldiv | op_mthi | op_mtlo | i_hilo_read);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed scoreboard bench for ex_muldiv_unit: expected HI/LO pushed at issue,
// popped and compared by a monitor whenever o_done or o_div_by_zero pulses.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [5:0]  alu_op;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        hilo_read;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_busy;
    logic        o_stall;
    logic        o_done;
    logic        o_div_by_zero;

    typedef struct {
        bit          dbz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    ex_muldiv_unit dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_valid       (valid),
        .i_alu_op      (alu_op),
        .i_data_a      (data_a),
        .i_data_b      (data_b),
        .i_hilo_read   (hilo_read),
        .o_hi          (o_hi),
        .o_lo          (o_lo),
        .o_busy        (o_busy),
        .o_stall       (o_stall),
        .o_done        (o_done),
        .o_div_by_zero (o_div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input bit dbz, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.dbz = dbz;
        e.hi  = hi;
        e.lo  = lo;
        exp_q.push_back(e);
    endtask

    // Present one instruction for exactly one accept edge; returns #1 after that edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid  = 1'b1;
        alu_op = op;
        data_a = a;
        data_b = b;
        @(posedge clk);
        #1;
        valid  = 1'b0;
        alu_op = 6'h00;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!o_busy) break;
            n++;
        end
    endtask

    // Monitor: every completion or divide-by-zero pulse must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_done || o_div_by_zero) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: done=%0b dbz=%0b hi=%h lo=%h, none expected",
                             o_done, o_div_by_zero, o_hi, o_lo);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_is_dbz", {31'b0, o_div_by_zero}, {31'b0, e.dbz});
                    chk("pulse_is_done", {31'b0, o_done}, {31'b0, !e.dbz});
                    chk("result_hi", o_hi, e.hi);
                    chk("result_lo", o_lo, e.lo);
                end
            end
        end
    end

    initial begin
        int n;
        rst       = 1'b1;
        valid     = 1'b0;
        alu_op    = 6'h00;
        data_a    = '0;
        data_b    = '0;
        hilo_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_hi", o_hi, 32'h0);
        chk("reset_lo", o_lo, 32'h0);
        chk("reset_busy", {31'b0, o_busy}, 32'h0);
        chk("reset_done", {31'b0, o_done}, 32'h0);
        chk("reset_dbz", {31'b0, o_div_by_zero}, 32'h0);
        chk("reset_stall", {31'b0, o_stall}, 32'h0);

        // MULT 7 * -3 = -21
        push(1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
        issue(6'h18, 32'd7, 32'hFFFFFFFD);
        wait_idle(n);
        chk("mult_busy_cycles", 32'(n), 32'd33);

        // MULTU max * max
        push(1'b0, 32'hFFFFFFFE, 32'h00000001);
        issue(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(n);
        chk("multu_busy_cycles", 32'(n), 32'd33);

        // DIV -7 / 2 = -3 rem -1
        push(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(6'h1A, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        chk("div_busy_cycles", 32'(n), 32'd33);

        // DIV overflow case
        push(1'b0, 32'h00000000, 32'h80000000);
        issue(6'h1A, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        chk("div_ovf_busy_cycles", 32'(n), 32'd33);

        // DIVU 1000 / 7 = 142 rem 6
        push(1'b0, 32'd6, 32'd142);
        issue(6'h1B, 32'd1000, 32'd7);
        wait_idle(n);

        // Preset HI/LO, then DIVU by zero leaves them alone
        issue(6'h11, 32'h12345678, 32'h0);
        chk("mthi_hi", o_hi, 32'h12345678);
        issue(6'h13, 32'h12345678, 32'h0);
        chk("mtlo_lo", o_lo, 32'h12345678);
        chk("mt_no_busy", {31'b0, o_busy}, 32'h0);
        push(1'b1, 32'h12345678, 32'h12345678);
        issue(6'h1B, 32'd100, 32'd0);
        wait_idle(n);
        chk("dbz_busy_cycles", 32'(n), 32'd0);
        repeat (3) @(negedge clk);

        // Stall interaction while a MULT 3 * 5 runs
        push(1'b0, 32'h0, 32'd15);
        issue(6'h18, 32'd3, 32'd5);
        @(negedge clk);
        valid     = 1'b1;
        alu_op    = 6'h10;
        hilo_read = 1'b1;
        #1;
        chk("stall_mfhi", {31'b0, o_stall}, 32'h1);
        @(negedge clk);
        hilo_read = 1'b0;
        alu_op    = 6'h13;
        data_a    = 32'hDEADBEEF;
        #1;
        chk("stall_mtlo", {31'b0, o_stall}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("stalled_mtlo_no_write", o_lo, 32'h12345678);
        alu_op = 6'h20;
        #1;
        chk("no_stall_other_funct", {31'b0, o_stall}, 32'h0);
        alu_op = 6'h13;
        valid  = 1'b0;
        #1;
        chk("no_stall_bubble", {31'b0, o_stall}, 32'h0);
        alu_op = 6'h00;
        wait_idle(n);
        issue(6'h13, 32'hA5A5A5A5, 32'h0);
        chk("mtlo_after_done", o_lo, 32'hA5A5A5A5);
        chk("mtlo_keeps_hi", o_hi, 32'h0);

        // Reset while RUN counter is 10
        issue(6'h19, 32'h0000FFFF, 32'h0000FFFF);
        repeat (11) @(negedge clk);
        chk("busy_before_reset", {31'b0, o_busy}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", {31'b0, o_busy}, 32'h0);
        chk("abort_hi", o_hi, 32'h0);
        chk("abort_lo", o_lo, 32'h0);
        repeat (40) @(negedge clk);
        chk("abort_stays_idle", {31'b0, o_busy}, 32'h0);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the registered ALU opcode and the two operands, and owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle.
- While busy, raises a stall request that the hazard logic uses to drop the pipeline enable.

Parameters:
- DATA_SIZE, 32, operand and HI/LO width.
- OPCODE_SIZE, 6, width of the ALU opcode (funct) field.
- CNT_SIZE, 6, iteration counter width; must hold DATA_SIZE.

Ports:
- i_clock  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  EX-stage instruction valid (pipeline enabled, not a bubble).
- i_alu_op  in  OPCODE_SIZE  funct code from ID/EX.
- i_data_a  in  DATA_SIZE  rs operand (already forwarded).
- i_data_b  in  DATA_SIZE  rt operand (already forwarded).
- i_hilo_read  in  1  EX instruction is MFHI/MFLO.
- o_hi  out  DATA_SIZE  HI register.
- o_lo  out  DATA_SIZE  LO register.
- o_busy  out  1  iterative operation in progress.
- o_stall  out  1  combinational stall request to hazard unit.
- o_done  out  1  one-cycle pulse: HI/LO just updated by mul/div.
- o_div_by_zero  out  1  one-cycle pulse: divide with i_data_b == 0.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; HI=LO=0; counter=0.
  - o_busy=0, o_done=0, o_div_by_zero=0, o_stall=0.
  - Reset mid-operation aborts the operation; HI/LO read 0 the next cycle.
- Funct codes: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13.
- Acceptance:
  - An instruction is accepted only when state==IDLE and i_valid==1.
  - Any other funct is ignored.
- MTHI/MTLO:
  - On accept, HI (or LO) <= i_data_a at that edge.
  - No busy, no o_done.
- States:
  - IDLE: on accepted mul/div, latch the operand magnitudes and sign flags, counter=0, go to RUN.
  - Divide by zero: no RUN; HI/LO unchanged; o_div_by_zero=1 next cycle; stay IDLE.
  - RUN, multiply: shift-add, 1 bit per cycle on the 64-bit accumulator.
  - RUN, divide: restoring division, 1 quotient bit per cycle.
  - RUN exit: after DATA_SIZE cycles (counter==DATA_SIZE-1), go to FIX.
  - FIX: apply sign correction, write HI/LO, go to IDLE; o_done=1 in the following cycle.
- Signed operations:
  - Operands use unsigned magnitudes; |0x80000000| = 0x80000000.
  - Product is negated (64-bit) if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
- Results:
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
  - Overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (falls out naturally).
- Latency: accept edge at cycle 0; busy during cycles 1..33; HI/LO new at cycle 34; o_done high at cycle 34.
- o_busy = (state != IDLE).
- o_stall = o_busy & i_valid & (mul/div/MTHI/MTLO funct | i_hilo_read).
  - Stalled instructions are not accepted; they are re-presented when the pipeline resumes.
- During RUN, operands/opcode inputs are don't-care; internal latched copies are used.
- Back-to-back: a new op may be accepted in the IDLE cycle immediately after FIX.

Decomposition:
- Shared package:
  - funct constants (FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO).
  - state encoding (IDLE, RUN, FIX).
  - DATA_SIZE default.
- Sub-module muldiv_iter_core:
  - holds the 64-bit accumulator/remainder and the per-cycle shift-add / restoring-subtract step.
  - control: start, op-is-divide, step enable.
  - FSM, sign handling, HI/LO and stall logic stay in ex_muldiv_unit.

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3): o_busy high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB, o_done 1-cycle pulse.
- MULTU a=b=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU a=100, b=0 with HI=LO=0x12345678 preset via MTHI/MTLO: o_div_by_zero pulses once, o_busy never asserts, HI/LO unchanged.
- Busy interaction: during RUN, present i_valid with i_hilo_read=1, then with MTLO. Expect o_stall=1 and LO not written. After o_done, MTLO a=0xA5A5A5A5 gives LO=0xA5A5A5A5 the next cycle.
- Reset at RUN counter=10: next cycle state IDLE, o_busy=0, HI=LO=0, no o_done pulse.
